ccff_chain_loader: RTL and testbench

- Sequences the configuration-chain shift registers: memories built from p_ccff cells daisy-chained head→tail, e.g. mux_tree and LUT memories.
- Accepts configuration words over a valid/ready stream, serializes them onto ccff_head and drives a chain shift enable, one bit per prog_clk.
- Counts exactly CHAIN_LEN bits, then stops and signals done.
- Sits between the bitstream source (SPI/scan front end) and the fabric's top-level chain head.

---
 rtl/ccff_chain_loader_if.sv | 12 +
 rtl/ccff_chain_loader.sv | 135 +++++++++++++
 tb/tb_ccff_chain_loader.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ccff_chain_loader_if.sv
// Word stream into the configuration-chain loader: source drives data/valid, loader drives ready.
// Latency: none, wires only. Backpressure: the slave holds s_ready low outside its word-accept states.
interface ccff_chain_loader_if #(
    parameter int WORD_W = 8
);
    logic [WORD_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/ccff_chain_loader.sv
// Serializes config words onto a p_ccff chain head, LSB first, stopping after exactly CHAIN_LEN bits.
// Latency: bit 0 appears on ccff_head one cycle after the word handshake; WORD_W+1 cycles per word.
// Backpressure: s_ready only in LOAD (and PCHK when CCFF_LOADER_PARITY_EN adds a trailing parity word).
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 64,
    parameter int WORD_W    = 8,
    parameter int CNT_W     = 16
) (
    input  logic               prog_clk,
    input  logic               prog_reset_n,
    input  logic               start,
    input  logic               abort,
    ccff_chain_loader_if.slave s,
    output logic               ccff_head,
    output logic               ccff_shift_en,
    input  logic               ccff_tail,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   bits_loaded,
    output logic               error
);

    localparam int               WB_W = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] LEN  = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] WLEN = CNT_W'(WORD_W);

`ifdef CCFF_LOADER_PARITY_EN
    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, DONE, PCHK} state_t;
`else
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
`endif

    state_t            state;
    logic [WORD_W-1:0] sreg;
    logic [WB_W-1:0]   bits_left;
    logic [WB_W-1:0]   word_bits;
    logic [CNT_W-1:0]  remaining;
    logic [CNT_W-1:0]  bits_inc;
    logic              last_bit;
    logic              unused_tail;

    // The tail is not needed for sequencing; the parity check works on the shifted stream.
    assign unused_tail = ccff_tail;

    always_comb begin
        remaining = LEN - bits_loaded;
        word_bits = (remaining < WLEN) ? WB_W'(remaining) : WB_W'(WORD_W);
        bits_inc  = bits_loaded + CNT_W'(1);
        last_bit  = (bits_inc == LEN);
    end

`ifdef CCFF_LOADER_PARITY_EN
    logic parity;

    assign s.s_ready = (state == LOAD) || (state == PCHK);
    assign busy      = (state == LOAD) || (state == SHIFT) || (state == PCHK);
`else
    assign s.s_ready = (state == LOAD);
    assign busy      = (state == LOAD) || (state == SHIFT);
    assign error     = 1'b0;
`endif
    assign done = (state == DONE);

    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            state         <= IDLE;
            sreg          <= '0;
            bits_left     <= '0;
            bits_loaded   <= '0;
            ccff_head     <= 1'b0;
            ccff_shift_en <= 1'b0;
`ifdef CCFF_LOADER_PARITY_EN
            parity        <= 1'b0;
            error         <= 1'b0;
`endif
        end else begin
            ccff_shift_en <= 1'b0;
            // abort wins over start and over a word handshaking in the same cycle
            if (abort) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (start) begin
                            state       <= LOAD;
                            bits_loaded <= '0;
`ifdef CCFF_LOADER_PARITY_EN
                            parity      <= 1'b0;
                            error       <= 1'b0;
`endif
                        end
                    end
                    LOAD: begin
                        if (s.s_valid) begin
                            sreg      <= s.s_data;
                            bits_left <= word_bits;
                            state     <= SHIFT;
                        end
                    end
                    SHIFT: begin
                        ccff_head     <= sreg[0];
                        ccff_shift_en <= 1'b1;
                        sreg          <= sreg >> 1;
                        bits_loaded   <= bits_inc;
                        bits_left     <= bits_left - WB_W'(1);
`ifdef CCFF_LOADER_PARITY_EN
                        parity        <= parity ^ sreg[0];
`endif
                        if (bits_left == WB_W'(1)) begin
                            if (last_bit) begin
`ifdef CCFF_LOADER_PARITY_EN
                                state <= PCHK;
`else
                                state <= DONE;
`endif
                            end else begin
                                state <= LOAD;
                            end
                        end
                    end
`ifdef CCFF_LOADER_PARITY_EN
                    PCHK: begin
                        if (s.s_valid) begin
                            error <= s.s_data[0] ^ parity;
                            state <= DONE;
                        end
                    end
`endif
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Scoreboard bench: two loaders (16- and 20-cell chains) with model chains; a negedge monitor checks each shifted bit.
module tb_ccff_chain_loader;

    logic        prog_clk = 1'b0;
    logic        prog_reset_n;
    logic        st [2];
    logic        ab [2];
    logic        vld[2];
    logic [7:0]  dat[2];
    logic        rdy[2];
    logic        sen[2];
    logic        head[2];
    logic        busy_o[2];
    logic        done_o[2];
    logic        err_o[2];
    logic [15:0] bl[2];
    logic [15:0] chain0 = '0;
    logic [19:0] chain1 = '0;

    bit q0[$];
    bit q1[$];
    int senc[2] = '{0, 0};
    int pushed[2];
    int n_vec = 0;
    int n_err = 0;

    ccff_chain_loader_if #(.WORD_W(8)) if0 ();
    ccff_chain_loader_if #(.WORD_W(8)) if1 ();

    assign if0.s_valid = vld[0];
    assign if0.s_data  = dat[0];
    assign rdy[0]      = if0.s_ready;
    assign if1.s_valid = vld[1];
    assign if1.s_data  = dat[1];
    assign rdy[1]      = if1.s_ready;

    ccff_chain_loader #(.CHAIN_LEN(16), .WORD_W(8), .CNT_W(16)) dut16 (
        .prog_clk(prog_clk), .prog_reset_n(prog_reset_n), .start(st[0]), .abort(ab[0]),
        .s(if0), .ccff_head(head[0]), .ccff_shift_en(sen[0]), .ccff_tail(chain0[15]),
        .busy(busy_o[0]), .done(done_o[0]), .bits_loaded(bl[0]), .error(err_o[0])
    );

    ccff_chain_loader #(.CHAIN_LEN(20), .WORD_W(8), .CNT_W(16)) dut20 (
        .prog_clk(prog_clk), .prog_reset_n(prog_reset_n), .start(st[1]), .abort(ab[1]),
        .s(if1), .ccff_head(head[1]), .ccff_shift_en(sen[1]), .ccff_tail(chain1[19]),
        .busy(busy_o[1]), .done(done_o[1]), .bits_loaded(bl[1]), .error(err_o[1])
    );

    always #5 prog_clk = ~prog_clk;

    // Model chains: cell 0 takes the head, so the first bit shifted ends in the top cell.
    always @(posedge prog_clk) begin
        if (sen[0]) chain0 <= {chain0[14:0], head[0]};
        if (sen[1]) chain1 <= {chain1[18:0], head[1]};
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        n_vec++;
        n_err++;
        $display("FAIL %s: bound expired, event never seen (required within budget)", nm);
    endtask

    task automatic tick();
        @(posedge prog_clk);
        #1;
    endtask

    initial begin
        forever begin
            @(negedge prog_clk);
            if (sen[0]) begin
                senc[0]++;
                check("dut16 bit expected", 32'(q0.size() > 0), 1);
                if (q0.size() > 0) check("dut16 ccff_head", head[0], q0.pop_front());
            end
            if (sen[1]) begin
                senc[1]++;
                check("dut20 bit expected", 32'(q1.size() > 0), 1);
                if (q1.size() > 0) check("dut20 ccff_head", head[1], q1.pop_front());
            end
        end
    end

    task automatic push_word(input int d, input logic [7:0] w);
        int len;
        int k;
        len = (d == 0) ? 16 : 20;
        k = len - pushed[d];
        if (k > 8) k = 8;
        for (int i = 0; i < k; i++) begin
            if (d == 0) q0.push_back(w[i]);
            else        q1.push_back(w[i]);
        end
        pushed[d] += k;
    endtask

    task automatic pulse_start(input int d);
        st[d] = 1'b1;
        tick();
        st[d] = 1'b0;
        pushed[d] = 0;
    endtask

    task automatic send_word(input int d, input logic [7:0] w, input int gap, input bit is_par);
        int t;
        if (gap > 0) begin
            t = 0;
            while (!rdy[d] && t < 100) begin tick(); t++; end
            if (!rdy[d]) timeout("stall wait for LOAD");
            for (int i = 0; i < gap; i++) begin
                tick();
                check("stall s_ready held", rdy[d], 1);
                check("stall no shift_en", sen[d], 0);
            end
        end
        if (!is_par) push_word(d, w);
        vld[d] = 1'b1;
        dat[d] = w;
        t = 0;
        while (!rdy[d] && t < 100) begin tick(); t++; end
        if (!rdy[d]) timeout("word handshake");
        tick();
        vld[d] = 1'b0;
    endtask

    task automatic run_load(input int d, input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                            input int nw, input int gap, input logic [7:0] pw, input logic exp_err,
                            input logic [31:0] exp_chain, input string nm);
        int base;
        int t;
        int rcnt;
        int len;
        len  = (d == 0) ? 16 : 20;
        base = senc[d];
        pulse_start(d);
        send_word(d, w0, gap, 1'b0);
        if (nw > 1) send_word(d, w1, gap, 1'b0);
        if (nw > 2) send_word(d, w2, gap, 1'b0);
`ifdef CCFF_LOADER_PARITY_EN
        send_word(d, pw, 0, 1'b1);
`endif
        t = 0;
        rcnt = 0;
        while (!done_o[d] && t < 200) begin
            if (rdy[d]) rcnt++;
            tick();
            t++;
        end
        if (!done_o[d]) timeout({nm, " done"});
`ifndef CCFF_LOADER_PARITY_EN
        check({nm, " s_ready after last word"}, rcnt, 0);
`endif
        tick();
        check({nm, " done"}, done_o[d], 1);
        check({nm, " busy"}, busy_o[d], 0);
        check({nm, " bits_loaded"}, bl[d], len);
        check({nm, " shift_en count"}, senc[d] - base, len);
        check({nm, " chain"}, (d == 0) ? 32'(chain0) : 32'(chain1), exp_chain);
        check({nm, " scoreboard drained"}, (d == 0) ? q0.size() : q1.size(), 0);
`ifdef CCFF_LOADER_PARITY_EN
        check({nm, " error"}, err_o[d], exp_err);
`else
        check({nm, " error"}, err_o[d], 0);
        if (pw != 8'h00 || exp_err) t = 0;
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        prog_reset_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            st[d] = 1'b0; ab[d] = 1'b0; vld[d] = 1'b0; dat[d] = 8'h00; pushed[d] = 0;
        end
        #12;
        for (int d = 0; d < 2; d++) begin
            check("reset s_ready", rdy[d], 0);
            check("reset shift_en", sen[d], 0);
            check("reset ccff_head", head[d], 0);
            check("reset busy", busy_o[d], 0);
            check("reset done", done_o[d], 0);
            check("reset error", err_o[d], 0);
            check("reset bits_loaded", bl[d], 0);
        end
        prog_reset_n = 1'b1;
        tick();

        // A5,3C tail-first: first bit shifted sits in cell 15, giving 0xA53C top-down.
        run_load(0, 8'hA5, 8'h3C, 8'h00, 2, 0, 8'h01, 1'b1, 32'h0000A53C, "dut16 A5_3C");
        // 20 cells: last word contributes only its low 4 ones.
        run_load(1, 8'hFF, 8'h00, 8'hFF, 3, 0, 8'h00, 1'b0, 32'h000FF00F, "dut20 FF_00_FF");
        run_load(0, 8'hA5, 8'h3C, 8'h00, 2, 5, 8'h00, 1'b0, 32'h0000A53C, "dut16 stalled");

        // Abort after five bits of the first word.
        pulse_start(0);
        push_word(0, 8'hA5);
        vld[0] = 1'b1;
        dat[0] = 8'hA5;
        t = 0;
        while (bl[0] != 16'd5 && t < 50) begin
            tick();
            t++;
            if (bl[0] != 16'd0) vld[0] = 1'b0;
        end
        vld[0] = 1'b0;
        if (bl[0] != 16'd5) timeout("abort wait for 5 bits");
        ab[0] = 1'b1;
        tick();
        ab[0] = 1'b0;
        check("abort busy", busy_o[0], 0);
        check("abort done", done_o[0], 0);
        check("abort shift_en", sen[0], 0);
        check("abort bits_loaded", bl[0], 5);
        check("abort s_ready", rdy[0], 0);
        check("abort chain low bits", chain0[4:0], 5'h14);
        q0.delete();
        tick();
        check("abort idle shift_en", sen[0], 0);
        run_load(0, 8'hA5, 8'h3C, 8'h00, 2, 0, 8'h01, 1'b1, 32'h0000A53C, "dut16 after abort");

        // Reset in the middle of a shift.
        pulse_start(0);
        push_word(0, 8'h5A);
        vld[0] = 1'b1;
        dat[0] = 8'h5A;
        t = 0;
        while (bl[0] != 16'd3 && t < 50) begin
            tick();
            t++;
            if (bl[0] != 16'd0) vld[0] = 1'b0;
        end
        vld[0] = 1'b0;
        if (bl[0] != 16'd3) timeout("reset wait for 3 bits");
        #2;
        prog_reset_n = 1'b0;
        #1;
        check("midreset shift_en", sen[0], 0);
        check("midreset ccff_head", head[0], 0);
        check("midreset busy", busy_o[0], 0);
        check("midreset s_ready", rdy[0], 0);
        check("midreset bits_loaded", bl[0], 0);
        check("midreset dut20 done", done_o[1], 0);
        #2;
        prog_reset_n = 1'b1;
        q0.delete();
        tick();
        check("post-reset s_ready", rdy[0], 0);
        check("post-reset busy", busy_o[0], 0);
        check("post-reset done", done_o[0], 0);
        run_load(0, 8'h3C, 8'hA5, 8'h00, 2, 0, 8'h00, 1'b0, 32'h00003CA5, "dut16 after reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
